// File: rtl/bcd_countdown_timer_pkg.sv
// timer_pkg: shared state encoding, digit limits and load saturation helper
package timer_pkg;
   typedef enum logic [1:0] {IDLE, RUNNING, PAUSED, DONE} timer_state_t;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [3:0] DIGIT_MAX = 4'd9;
   function automatic logic [3:0] sat_digit(input logic [3:0] v, input logic [3:0] max);
      return (v > max) ? max : v;
   endfunction
endpackage

// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: control, load and display signals of the countdown timer
interface bcd_countdown_timer_if;
   logic tick, load, start, stop, clear;
   logic [3:0] load_min, load_sec_tens, load_sec_ones;
   logic [3:0] min, sec_tens, sec_ones;
   logic running, done;
   modport master(
      output tick, load, start, stop, clear, load_min, load_sec_tens, load_sec_ones,
      input min, sec_tens, sec_ones, running, done
   );
   modport slave(
      input tick, load, start, stop, clear, load_min, load_sec_tens, load_sec_ones,
      output min, sec_tens, sec_ones, running, done
   );
endinterface

// File: rtl/bcd_countdown_timer_digit_down.sv
// bcd_digit_down: one BCD digit counting down, wrapping to WRAP_VAL and borrowing at 0
module bcd_digit_down
   import timer_pkg::*;
#(
   parameter logic [3:0] WRAP_VAL = DIGIT_MAX
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dec,
   input  logic       load_en,
   input  logic [3:0] load_val,
   input  logic       clr,
   output logic [3:0] digit,
   output logic       borrow
);
   logic [3:0] digit_q, digit_d;
   always_comb
      digit_d = clr ? 4'd0 : load_en ? load_val : !dec ? digit_q :
                (digit_q == 4'd0) ? WRAP_VAL : digit_q - 4'd1;
   always_ff @(posedge clk or posedge reset)
      if (reset) digit_q <= '0;
      else digit_q <= digit_d;
   assign digit = digit_q;
   assign borrow = dec && (digit_q == 4'd0);
endmodule

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: M:SS BCD countdown with load saturation, pause/resume and expiry pulse
module bcd_countdown_timer
   import timer_pkg::*;
#(
   parameter int MAX_MIN = 9
) (
   input logic clk,
   input logic reset,
   bcd_countdown_timer_if.slave bus
);
   localparam logic [3:0] MAX_MIN_D = 4'(MAX_MIN);
   timer_state_t state_q, state_d;
   logic running_q, running_d, done_q, done_d;
   logic zero, at_one, ld_en, stop_en, start_en, tick_en, expire;
   logic b_ones, b_tens, b_min;
   logic [3:0] d_min, d_tens, d_ones;
   assign zero = {d_min, d_tens, d_ones} == 12'h000;
   assign at_one = {d_min, d_tens, d_ones} == 12'h001;
   // each enable is already masked by every higher-priority control that takes effect
   always_comb begin
      ld_en = !bus.clear && bus.load && state_q != RUNNING;
      stop_en = !bus.clear && !ld_en && bus.stop && state_q == RUNNING;
      start_en = !bus.clear && !ld_en && !stop_en && bus.start && !zero &&
                 (state_q == IDLE || state_q == PAUSED);
      tick_en = !bus.clear && !ld_en && !stop_en && !start_en && bus.tick && state_q == RUNNING;
      expire = tick_en && (at_one || b_min);
      state_d = (bus.clear || ld_en) ? IDLE : stop_en ? PAUSED : start_en ? RUNNING :
                expire ? DONE : state_q;
   end
   always_comb begin
      running_d = state_d == RUNNING;
      done_d = expire;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q <= IDLE;
         running_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         running_q <= running_d;
         done_q <= done_d;
      end
   bcd_digit_down #(.WRAP_VAL(DIGIT_MAX)) u_ones (
      .clk(clk), .reset(reset), .dec(tick_en), .load_en(ld_en),
      .load_val(sat_digit(bus.load_sec_ones, DIGIT_MAX)), .clr(bus.clear),
      .digit(d_ones), .borrow(b_ones)
   );
   bcd_digit_down #(.WRAP_VAL(SEC_TENS_MAX)) u_tens (
      .clk(clk), .reset(reset), .dec(b_ones), .load_en(ld_en),
      .load_val(sat_digit(bus.load_sec_tens, SEC_TENS_MAX)), .clr(bus.clear),
      .digit(d_tens), .borrow(b_tens)
   );
   bcd_digit_down #(.WRAP_VAL(MAX_MIN_D)) u_min (
      .clk(clk), .reset(reset), .dec(b_tens), .load_en(ld_en),
      .load_val(sat_digit(bus.load_min, MAX_MIN_D)), .clr(bus.clear),
      .digit(d_min), .borrow(b_min)
   );
   assign bus.min = d_min;
   assign bus.sec_tens = d_tens;
   assign bus.sec_ones = d_ones;
   assign bus.running = running_q;
   assign bus.done = done_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: directed stimulus checked against a seconds-count model every cycle
module tb_bcd_countdown_timer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int pass_cnt = 0;
   int total_cnt = 0;
   int m_cnt = 0;
   int m_st = 0;
   bit m_done = 1'b0;
   bcd_countdown_timer_if bus();
   bcd_countdown_timer #(.MAX_MIN(9)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask
   function automatic int dg();
      return int'({bus.min, bus.sec_tens, bus.sec_ones});
   endfunction
   function automatic int sat(input int v, input int max);
      return (v > max) ? max : v;
   endfunction
   // model: 0 idle, 1 running, 2 paused, 3 done; count held as plain seconds
   always @(posedge clk or posedge reset)
      if (reset) begin
         m_cnt = 0;
         m_st = 0;
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (bus.clear) begin
            m_cnt = 0;
            m_st = 0;
         end else if (bus.load && m_st != 1) begin
            m_cnt = sat(bus.load_min, 9) * 60 + sat(bus.load_sec_tens, 5) * 10 + sat(bus.load_sec_ones, 9);
            m_st = 0;
         end else if (bus.stop && m_st == 1) m_st = 2;
         else if (bus.start && (m_st == 0 || m_st == 2) && m_cnt != 0) m_st = 1;
         else if (bus.tick && m_st == 1) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
               m_st = 3;
               m_done = 1'b1;
            end
         end
      end
   always @(negedge clk)
      if (!reset) begin
         check("model_min", bus.min, m_cnt / 60);
         check("model_sec_tens", bus.sec_tens, (m_cnt % 60) / 10);
         check("model_sec_ones", bus.sec_ones, m_cnt % 10);
         check("model_running", bus.running, m_st == 1);
         check("model_done", bus.done, m_done);
      end
   task automatic drive(input logic t, ld, st, sp, cl,
                        input logic [3:0] lm = 4'd0, lt = 4'd0, lo = 4'd0);
      bus.tick = t; bus.load = ld; bus.start = st; bus.stop = sp; bus.clear = cl;
      bus.load_min = lm; bus.load_sec_tens = lt; bus.load_sec_ones = lo;
      @(negedge clk);
      bus.tick = 0; bus.load = 0; bus.start = 0; bus.stop = 0; bus.clear = 0;
   endtask
   initial begin
      bus.tick = 0; bus.load = 0; bus.start = 0; bus.stop = 0; bus.clear = 0;
      bus.load_min = 0; bus.load_sec_tens = 0; bus.load_sec_ones = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("reset_digits", dg(), 12'h000);
      check("reset_running", bus.running, 0);
      check("reset_done", bus.done, 0);
      drive(0, 1, 0, 0, 0, 4'd1, 4'd0, 4'd0);
      check("load_100", dg(), 12'h100);
      drive(0, 0, 1, 0, 0);
      check("start_running", bus.running, 1);
      drive(1, 0, 0, 0, 0);
      check("wrap_059", dg(), 12'h059);
      drive(0, 1, 0, 0, 0, 4'd3, 4'd3, 4'd3);
      check("load_in_running_ignored", dg(), 12'h059);
      check("load_in_running_still_run", bus.running, 1);
      drive(0, 0, 0, 1, 0);
      drive(0, 1, 0, 0, 0, 4'hC, 4'd7, 4'hF);
      check("load_saturate_959", dg(), 12'h959);
      drive(0, 1, 0, 0, 1, 4'd1, 4'd2, 4'd3);
      check("clear_over_load", dg(), 12'h000);
      drive(0, 0, 1, 0, 0);
      check("start_at_zero_idle", bus.running, 0);
      drive(0, 1, 0, 0, 0, 4'd0, 4'd0, 4'd3);
      drive(0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0);
      check("expiry_002", dg(), 12'h002);
      drive(1, 0, 0, 0, 0);
      check("expiry_001", dg(), 12'h001);
      check("expiry_no_early_done", bus.done, 0);
      drive(1, 0, 0, 0, 0);
      check("expiry_000", dg(), 12'h000);
      check("expiry_done", bus.done, 1);
      check("expiry_not_running", bus.running, 0);
      drive(0, 0, 1, 0, 0);
      check("done_one_cycle", bus.done, 0);
      drive(1, 0, 1, 0, 0);
      check("done_start_tick_hold", dg(), 12'h000);
      check("done_no_retrigger", bus.running, 0);
      drive(0, 1, 0, 0, 0, 4'd0, 4'd4, 4'd5);
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 0, 1, 0);
      repeat (5) drive(1, 0, 0, 0, 0);
      check("pause_hold_045", dg(), 12'h045);
      drive(0, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 0);
      check("resume_044", dg(), 12'h044);
      drive(0, 0, 0, 1, 0);
      drive(0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd0);
      drive(0, 0, 1, 0, 0);
      drive(1, 0, 0, 1, 0);
      check("stop_tick_hold_010", dg(), 12'h010);
      check("stop_tick_paused", bus.running, 0);
      drive(0, 0, 0, 0, 1);
      drive(0, 1, 0, 0, 0, 4'd0, 4'd2, 4'd0);
      drive(1, 0, 1, 0, 0);
      check("start_tick_no_dec", dg(), 12'h020);
      check("start_tick_running", bus.running, 1);
      drive(1, 0, 0, 0, 0);
      check("first_dec_019", dg(), 12'h019);
      drive(0, 0, 0, 0, 1);
      drive(0, 1, 0, 0, 0, 4'd5, 4'd3, 4'd0);
      drive(0, 0, 1, 0, 0);
      check("pre_reset_530", dg(), 12'h530);
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("async_reset_digits", dg(), 12'h000);
      check("async_reset_running", bus.running, 0);
      check("async_reset_done", bus.done, 0);
      #1 reset = 1'b0;
      drive(1, 0, 0, 0, 0);
      check("post_reset_idle", dg(), 12'h000);
      check("post_reset_no_done", bus.done, 0);
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
